// File: rtl/eq_menu_pkg.sv
// Shared types for the equaliser front-panel controller: FSM states, menu items
// and a small helper for write-port decoding.
package eq_menu_pkg;

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_IDLE       = 4'd1,
    ST_MENU       = 4'd2,
    ST_BAND_SEL   = 4'd3,
    ST_SET_GAIN   = 4'd4,
    ST_WRITE1     = 4'd5,
    ST_SET_OFFSET = 4'd6,
    ST_PRESET_SEL = 4'd7,
    ST_WRITE_ALL  = 4'd8,
    ST_RESET_DSP  = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    M_EQ     = 3'd0,
    M_OFFSET = 3'd1,
    M_LOAD   = 3'd2,
    M_SAVE   = 3'd3,
    M_RESET  = 3'd4
  } menu_e;

  localparam int MENU_N = 5;

  function automatic logic is_write(state_e s);
    return (s == ST_WRITE1) || (s == ST_WRITE_ALL);
  endfunction

endpackage

// File: rtl/key_event.sv
// Rising-edge event generator for one debounced key, with optional auto-repeat
// after REPEAT_DLY cycles of hold and every REPEAT_PER cycles thereafter.
module key_event #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REPEAT_DLY = 5000000,
  parameter int REPEAT_PER = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_evt
);

  logic prev;
  logic rise;

  assign rise = i_level & ~prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) prev <= 1'b0;
    else       prev <= i_level;
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int CNT_W   = $clog2(CNT_MAX + 1);

      // Down-counter reaches zero exactly on each repeat slot while held.
      logic [CNT_W-1:0] cnt;
      logic             hit;

      assign hit = i_level & prev & (cnt == '0);

      always_ff @(posedge i_clk) begin
        if (i_rst)                     cnt <= '0;
        else if (rise)                 cnt <= CNT_W'(REPEAT_DLY - 1);
        else if (hit)                  cnt <= CNT_W'(REPEAT_PER - 1);
        else if (i_level && cnt != '0) cnt <= cnt - CNT_W'(1);
      end

      assign o_evt = rise | hit;
    end else begin : g_norep
      assign o_evt = rise;
    end
  endgenerate

endmodule

// File: rtl/eq_menu_ctrl.sv
// Equaliser front-panel controller: key events, menu/band/gain/offset/preset FSM
// and a valid/ready gain write port towards the DSP.
module eq_menu_ctrl
  import eq_menu_pkg::*;
#(
  parameter int N_BAND     = 7,
  parameter int GAIN_W     = 16,
  parameter int GAIN_MAX   = 12,
  parameter int GAIN_MIN   = -12,
  parameter int N_OFFSET   = 4,
  parameter int N_PRESET   = 4,
  parameter int REPEAT_DLY = 5000000,
  parameter int REPEAT_PER = 1000000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_select,
  input  logic                          i_back,
  input  logic                          i_up,
  input  logic                          i_down,
  input  logic                          i_init_done,
  output logic                          o_init_start,
  output logic [3:0]                    o_state,
  output logic [2:0]                    o_menu_sel,
  output logic [$clog2(N_BAND)-1:0]     o_band,
  output logic [GAIN_W-1:0]             o_gain,
  output logic [$clog2(N_OFFSET)-1:0]   o_offset,
  output logic [$clog2(N_PRESET)-1:0]   o_preset,
  output logic                          o_dsp_reset,
  output logic                          o_wr_valid,
  output logic [$clog2(N_BAND)-1:0]     o_wr_band,
  output logic [GAIN_W-1:0]             o_wr_gain,
  input  logic                          i_wr_ready
);

  localparam int BAND_W = $clog2(N_BAND);
  localparam int OFF_W  = $clog2(N_OFFSET);
  localparam int PRE_W  = $clog2(N_PRESET);

  localparam logic signed [GAIN_W-1:0] GMAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] GMIN = GAIN_W'(GAIN_MIN);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BAND - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(N_OFFSET - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(N_PRESET - 1);
  localparam menu_e             MENU_LAST = menu_e'(MENU_N - 1);

  // Key order: 0 back, 1 select, 2 up, 3 down; only up/down auto-repeat.
  logic [3:0] key_lvl, key_evt;
  assign key_lvl = {i_down, i_up, i_select, i_back};

  generate
    for (genvar k = 0; k < 4; k++) begin : g_key
      key_event #(
        .REPEAT_EN  (k >= 2),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
      ) u_key (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (key_lvl[k]),
        .o_evt   (key_evt[k])
      );
    end
  endgenerate

  logic e_back, e_sel, e_up, e_dn;
  assign e_back = key_evt[0];
  assign e_sel  = key_evt[1] & ~key_evt[0];
  assign e_up   = key_evt[2] & ~|key_evt[1:0];
  assign e_dn   = key_evt[3] & ~|key_evt[2:0];

  state_e                                   state, state_d;
  menu_e                                    menu_sel, menu_d;
  logic [BAND_W-1:0]                        band, band_d, wr_idx, idx_d;
  logic [OFF_W-1:0]                         offset, off_d;
  logic [PRE_W-1:0]                         preset, pre_d;
  logic [N_BAND-1:0][GAIN_W-1:0]            gains, gains_d;
  logic [N_PRESET-1:0][N_BAND-1:0][GAIN_W-1:0] presets, presets_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_INIT;
      menu_sel <= M_EQ;
      band     <= '0;
      wr_idx   <= '0;
      offset   <= '0;
      preset   <= '0;
      gains    <= '0;
      presets  <= '0;
    end else begin
      state    <= state_d;
      menu_sel <= menu_d;
      band     <= band_d;
      wr_idx   <= idx_d;
      offset   <= off_d;
      preset   <= pre_d;
      gains    <= gains_d;
      presets  <= presets_d;
    end
  end

  always_comb begin
    state_d   = state;
    menu_d    = menu_sel;
    band_d    = band;
    idx_d     = wr_idx;
    off_d     = offset;
    pre_d     = preset;
    gains_d   = gains;
    presets_d = presets;
    case (state)
      ST_INIT: if (i_init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (e_sel) begin
          state_d = ST_MENU;
          menu_d  = M_EQ;
        end
      end
      ST_MENU: begin
        if (e_back) state_d = ST_IDLE;
        else if (e_sel) begin
          case (menu_sel)
            M_EQ: begin
              state_d = ST_BAND_SEL;
              band_d  = '0;
            end
            M_OFFSET:       state_d = ST_SET_OFFSET;
            M_LOAD, M_SAVE: state_d = ST_PRESET_SEL;
            M_RESET: begin
              // Clear on entry so gains/offset read zero during the pulse cycle.
              state_d = ST_RESET_DSP;
              gains_d = '0;
              off_d   = '0;
            end
            default: ;
          endcase
        end
        else if (e_up) menu_d = (menu_sel == MENU_LAST) ? M_EQ : menu_e'(menu_sel + 3'd1);
        else if (e_dn) menu_d = (menu_sel == M_EQ) ? MENU_LAST : menu_e'(menu_sel - 3'd1);
      end
      ST_BAND_SEL: begin
        if (e_back)     state_d = ST_MENU;
        else if (e_sel) state_d = ST_SET_GAIN;
        else if (e_up && band != BAND_LAST) band_d = band + BAND_W'(1);
        else if (e_dn && band != '0)        band_d = band - BAND_W'(1);
      end
      ST_SET_GAIN: begin
        if (e_back || e_sel) state_d = ST_WRITE1;
        else if (e_up && $signed(gains[band]) < GMAX) gains_d[band] = gains[band] + GAIN_W'(1);
        else if (e_dn && $signed(gains[band]) > GMIN) gains_d[band] = gains[band] - GAIN_W'(1);
      end
      ST_WRITE1: if (i_wr_ready) state_d = ST_BAND_SEL;
      ST_SET_OFFSET: begin
        if (e_back || e_sel) state_d = ST_MENU;
        else if (e_up && offset != OFF_LAST) off_d = offset + OFF_W'(1);
        else if (e_dn && offset != '0)       off_d = offset - OFF_W'(1);
      end
      ST_PRESET_SEL: begin
        if (e_back) state_d = ST_MENU;
        else if (e_sel) begin
          if (menu_sel == M_SAVE) begin
            presets_d[preset] = gains;
            state_d           = ST_MENU;
          end else begin
            gains_d = presets[preset];
            idx_d   = '0;
            state_d = ST_WRITE_ALL;
          end
        end
        else if (e_up && preset != PRE_LAST) pre_d = preset + PRE_W'(1);
        else if (e_dn && preset != '0)       pre_d = preset - PRE_W'(1);
      end
      ST_WRITE_ALL: begin
        if (i_wr_ready) begin
          if (wr_idx == BAND_LAST) begin
            state_d = ST_MENU;
            idx_d   = '0;
          end else begin
            idx_d = wr_idx + BAND_W'(1);
          end
        end
      end
      ST_RESET_DSP: state_d = ST_MENU;
      default:      state_d = ST_INIT;
    endcase
  end

  logic [BAND_W-1:0] wb;
  assign wb = (state == ST_WRITE1) ? band : wr_idx;

  assign o_init_start = (state == ST_INIT);
  assign o_state      = state;
  assign o_menu_sel   = menu_sel;
  assign o_band       = band;
  assign o_gain       = gains[band];
  assign o_offset     = offset;
  assign o_preset     = preset;
  assign o_dsp_reset  = (state == ST_RESET_DSP);
  assign o_wr_valid   = is_write(state);
  assign o_wr_band    = wb;
  assign o_wr_gain    = gains[wb];

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Directed bench for eq_menu_ctrl with an abstract per-cycle reference model.
module tb_eq_menu_ctrl;

  localparam int NB = 7, NP = 4, NO = 4, DLY = 20, PER = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic sel = 0, bk = 0, up = 0, dn = 0, init_done = 0, ready = 1;
  logic       init_start, dsp_reset, wr_valid;
  logic [3:0] st;
  logic [2:0] menu, band, wr_band;
  logic [15:0] gain, wr_gain;
  logic [1:0] offset, preset;

  eq_menu_ctrl #(
    .N_BAND(NB), .GAIN_W(16), .GAIN_MAX(12), .GAIN_MIN(-12), .N_OFFSET(NO),
    .N_PRESET(NP), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_select(sel), .i_back(bk), .i_up(up), .i_down(dn),
    .i_init_done(init_done), .o_init_start(init_start), .o_state(st),
    .o_menu_sel(menu), .o_band(band), .o_gain(gain), .o_offset(offset),
    .o_preset(preset), .o_dsp_reset(dsp_reset), .o_wr_valid(wr_valid),
    .o_wr_band(wr_band), .o_wr_gain(wr_gain), .i_wr_ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: states by number, gains as plain ints, key hold times.
  int m_st, m_menu, m_band, m_off, m_pre, m_idx, act;
  int m_gain[NB];
  int m_presets[NP][NB];
  int hold[4];
  bit prevl[4], lv[4], ev[4];

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_menu = 0; m_band = 0; m_off = 0; m_pre = 0; m_idx = 0;
      foreach (m_gain[b]) m_gain[b] = 0;
      foreach (m_presets[p, b]) m_presets[p][b] = 0;
      foreach (prevl[k]) begin prevl[k] = 0; hold[k] = 0; end
    end else begin
      lv = '{bk, sel, up, dn};
      foreach (lv[k]) begin
        ev[k] = 0;
        if (lv[k]) begin
          if (!prevl[k]) begin ev[k] = 1; hold[k] = 0; end
          else begin
            hold[k]++;
            ev[k] = (k >= 2) && hold[k] >= DLY && ((hold[k] - DLY) % PER == 0);
          end
        end
        prevl[k] = lv[k];
      end
      act = ev[0] ? 1 : ev[1] ? 2 : ev[2] ? 3 : ev[3] ? 4 : 0;
      case (m_st)
        0: if (init_done) m_st = 1;
        1: if (act == 2) begin m_st = 2; m_menu = 0; end
        2: case (act)
             1: m_st = 1;
             2: case (m_menu)
                  0: begin m_st = 3; m_band = 0; end
                  1: m_st = 6;
                  2, 3: m_st = 7;
                  default: begin m_st = 9; m_off = 0; foreach (m_gain[b]) m_gain[b] = 0; end
                endcase
             3: m_menu = (m_menu + 1) % 5;
             4: m_menu = (m_menu + 4) % 5;
             default: ;
           endcase
        3: case (act)
             1: m_st = 2;
             2: m_st = 4;
             3: if (m_band < NB - 1) m_band++;
             4: if (m_band > 0) m_band--;
             default: ;
           endcase
        4: case (act)
             1, 2: m_st = 5;
             3: if (m_gain[m_band] < 12) m_gain[m_band]++;
             4: if (m_gain[m_band] > -12) m_gain[m_band]--;
             default: ;
           endcase
        5: if (ready) m_st = 3;
        6: case (act)
             1, 2: m_st = 2;
             3: if (m_off < NO - 1) m_off++;
             4: if (m_off > 0) m_off--;
             default: ;
           endcase
        7: case (act)
             1: m_st = 2;
             2: if (m_menu == 3) begin
                  foreach (m_gain[b]) m_presets[m_pre][b] = m_gain[b];
                  m_st = 2;
                end else begin
                  foreach (m_gain[b]) m_gain[b] = m_presets[m_pre][b];
                  m_idx = 0; m_st = 8;
                end
             3: if (m_pre < NP - 1) m_pre++;
             4: if (m_pre > 0) m_pre--;
             default: ;
           endcase
        8: if (ready) begin if (m_idx == NB - 1) m_st = 2; else m_idx++; end
        9: m_st = 2;
        default: ;
      endcase
    end
  end

  bit cmp_en = 0;
  int dsp_pulses = 0;
  int wq_band[$], wq_gain[$];
  int wb;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(st), m_st);
      chk("init_start", int'(init_start), int'(m_st == 0));
      chk("menu_sel", int'(menu), m_menu);
      chk("band", int'(band), m_band);
      chk("gain", int'($signed(gain)), m_gain[m_band]);
      chk("offset", int'(offset), m_off);
      chk("preset", int'(preset), m_pre);
      chk("dsp_reset", int'(dsp_reset), int'(m_st == 9));
      chk("wr_valid", int'(wr_valid), int'(m_st == 5 || m_st == 8));
      if (m_st == 5 || m_st == 8) begin
        wb = (m_st == 5) ? m_band : m_idx;
        chk("wr_band", int'(wr_band), wb);
        chk("wr_gain", int'($signed(wr_gain)), m_gain[wb]);
      end
      if (dsp_reset) dsp_pulses++;
      if (wr_valid && ready) begin
        wq_band.push_back(int'(wr_band));
        wq_gain.push_back(int'($signed(wr_gain)));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // key: 0 back, 1 select, 2 up, 3 down
  task automatic press(input int key, input int times);
    for (int i = 0; i < times; i++) begin
      case (key)
        0: bk = 1; 1: sel = 1; 2: up = 1; default: dn = 1;
      endcase
      tick(1);
      bk = 0; sel = 0; up = 0; dn = 0;
      tick(1);
    end
  endtask

  task automatic set_gain(input int b, input int g);
    press(3, NB); press(2, b); press(1, 1);
    press(3, 25); press(2, g + 12);
    press(0, 1);
  endtask

  int sv[NB] = '{1, -2, 3, 0, 0, 0, 5};

  initial begin
    tick(1);
    cmp_en = 1;
    tick(1);
    chk("rst_state", int'(st), 0);
    chk("rst_init_start", int'(init_start), 1);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_menu", int'(menu), 0);
    rst = 0;
    tick(7);
    init_done = 1; tick(1); init_done = 0;
    chk("init_to_idle", int'(st), 1);
    chk("init_start_fall", int'(init_start), 0);

    press(1, 1);
    chk("idle_to_menu", int'(st), 2);
    press(2, 4);
    chk("menu_at_4", int'(menu), 4);
    press(2, 1);
    chk("menu_wrap_up", int'(menu), 0);
    press(3, 1);
    chk("menu_wrap_dn", int'(menu), 4);
    press(2, 1);

    press(1, 1);
    press(2, 2);
    chk("band_2", int'(band), 2);
    press(1, 1);
    press(2, 11);
    chk("gain_11", int'($signed(gain)), 11);
    for (int i = 0; i < 3; i++) begin
      press(2, 1);
      chk("gain_sat_max", int'($signed(gain)), 12);
    end
    ready = 0;
    sel = 1; tick(1); sel = 0;
    chk("w1_state", int'(st), 5);
    chk("w1_valid", int'(wr_valid), 1);
    chk("w1_band", int'(wr_band), 2);
    chk("w1_gain", int'($signed(wr_gain)), 12);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("w1_hold_state", int'(st), 5);
      chk("w1_hold_gain", int'($signed(wr_gain)), 12);
    end
    ready = 1; tick(1);
    chk("w1_to_band_sel", int'(st), 3);

    press(1, 1);
    dn = 1; tick(DLY + 3 * PER); dn = 0; tick(1);
    chk("repeat_4_decr", int'($signed(gain)), 8);
    press(0, 1);
    chk("repeat_back_band_sel", int'(st), 3);

    for (int b = 0; b < NB; b++) set_gain(b, sv[b]);
    press(0, 1);
    chk("back_to_menu", int'(st), 2);
    press(2, 3);
    press(1, 1);
    press(2, 1);
    press(1, 1);
    chk("saved_menu", int'(st), 2);
    chk("saved_slot", int'(preset), 1);

    dsp_pulses = 0;
    press(2, 1);
    press(1, 1);
    chk("dsp_pulse_once", dsp_pulses, 1);
    chk("reset_back_menu", int'(st), 2);
    chk("reset_gain_b6", int'($signed(gain)), 0);

    press(3, 2);
    press(1, 1);
    wq_band.delete(); wq_gain.delete();
    ready = 0;
    sel = 1; tick(1); sel = 0;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 2 == 1);
      tick(1);
      if (st == 4'd2) break;
    end
    ready = 1;
    chk("load_done_menu", int'(st), 2);
    chk("load_writes", wq_band.size(), NB);
    for (int b = 0; b < NB && b < wq_band.size(); b++) begin
      chk("load_band", wq_band[b], b);
      chk("load_gain", wq_gain[b], sv[b]);
    end

    sel = 1; bk = 1; tick(1); sel = 0; bk = 0; tick(1);
    chk("back_beats_select", int'(st), 1);

    press(1, 1);
    press(3, 3);
    press(1, 1);
    ready = 0;
    press(1, 1);
    chk("wall_state", int'(st), 8);
    chk("wall_valid", int'(wr_valid), 1);
    rst = 1; tick(1);
    chk("rst_mid_state", int'(st), 0);
    chk("rst_mid_valid", int'(wr_valid), 0);
    chk("rst_mid_init", int'(init_start), 1);
    rst = 0; ready = 1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
